// File: rtl/rf_pkg.sv
// Shared definitions for the register file slice.
//   clog2    : constant function used to size address ports from DEPTH
//   REG_ZERO : architectural zero register index (reads 0, never busy)
//   port_lo  : low bit offset of port 'port' in a packed multi-port bus
package rf_pkg;

    localparam int REG_ZERO = 0;

    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   we, wa          writeback: clears busy[wa]
//   iss_valid/wa    issue: sets busy[iss_wa] when accepted
//   iss_ready       issue can be accepted this cycle (WAW stall otherwise)
//   flush           synchronous clear of every busy bit, overrides issue
//   busy            per-register busy vector (bit 0 always 0)
//   busy_cnt, idle  registered count of busy registers, count == 0
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_wa,
    input  logic             flush,
    output logic             iss_ready,
    output logic [DEPTH-1:0] busy,
    output logic [AW:0]      busy_cnt,
    output logic             idle
);

    logic             wr_clr;
    logic             iss_fire;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [DEPTH-1:0] busy_next;

    always_comb begin
        // A busy destination may be re-issued only when its writeback lands
        // in the same cycle; otherwise the issuer must stall (WAW).
        iss_ready = (iss_wa == AW'(REG_ZERO)) || !busy[iss_wa] || (we && (wa == iss_wa));
        wr_clr    = we && (wa != AW'(REG_ZERO));
        iss_fire  = iss_valid && iss_ready && (iss_wa != AW'(REG_ZERO));
        // Count only real transitions: re-issue of a register being written
        // back keeps it busy, so neither counter direction moves.
        cnt_inc   = iss_fire && !busy[iss_wa];
        cnt_dec   = wr_clr && busy[wa] && !(iss_fire && (iss_wa == wa));
    end

    always_comb begin
        // NOTE: every bit gets a default before the conditional updates, so no latch is inferred.
        busy_next = busy;
        if (wr_clr) begin
            busy_next[wa] = 1'b0;
        end
        if (iss_fire) begin
            busy_next[iss_wa] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_next;
            if (flush) begin
                busy_cnt <= '0;
            end else begin
                busy_cnt <= busy_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
            end
        end
    end

    assign idle = (busy_cnt == '0);

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with busy-bit scoreboard and optional
// write-to-read bypass, for the decode stage.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   we, wa, wd         writeback port (register 0 is never written)
//   iss_valid, iss_wa  issue request marking iss_wa busy; iss_ready accepts it
//   flush              clear all busy bits (data write still happens)
//   ra, rd, rvalid     packed combinational read ports, rvalid = operand not pending
//   busy_cnt, idle     number of busy registers, no register busy
module regfile_sb
    import rf_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 32,
    parameter  int NREAD  = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [WIDTH-1:0]       wd,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_wa,
    output logic                   iss_ready,
    input  logic                   flush,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    output logic [NREAD-1:0]       rvalid,
    output logic [AW:0]            busy_cnt,
    output logic                   idle
);

    localparam bit USE_BYPASS = (BYPASS != 0);

    logic [WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0] busy;

    rf_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .flush     (flush),
        .iss_ready (iss_ready),
        .busy      (busy),
        .busy_cnt  (busy_cnt),
        .idle      (idle)
    );

    // NOTE: the storage array is reset on purpose: registers must read 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                rf[r] <= '0;
            end
        end else if (we && (wa != AW'(REG_ZERO))) begin
            rf[wa] <= wd;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = ra[port_lo(i, AW) +: AW];
        // A writeback to the same register this cycle supplies both the data
        // and the validity, so the consumer need not wait for the edge.
        assign hit  = USE_BYPASS && we && (wa != AW'(REG_ZERO)) && (wa == addr);

        assign rd[port_lo(i, WIDTH) +: WIDTH] = hit ? wd :
                                                (addr == AW'(REG_ZERO)) ? '0 : rf[addr];
        assign rvalid[i] = hit || !busy[addr];
    end

endmodule
